dds_capture_buffer: RTL
=======================

# dds_capture_buffer

Trigger-aligned sample capture buffer downstream of `DDS_selector`. Records the selected carrier (`sig_out`) and modulated output (`mod_out`) into a ring buffer on each sample strobe. Aligns the capture window to the rising edge of the modulation bit (LFSR bit 0) and keeps a fixed number of pre-trigger samples. Plays the window back over a valid/ready stream to the display/DAC path.

## Interface
- `DATA_W`, 12: width of each captured sample (matches DDS output width)
- `DEPTH`, 256: samples per capture window; power of two, ≥ 4
- `PRE_TRIG`, 32: samples retained before the trigger; 1 ≤ PRE_TRIG < DEPTH

- `clk`  in  1  system clock (CLOCK_50 domain)
- `reset`  in  1  asynchronous, active-low reset
- `en`  in  1  sample strobe; one sample is taken per cycle with `en`=1
- `arm`  in  1  single-cycle request to start a capture
- `trig_in`  in  1  modulation bit, already synchronised to `clk`
- `sig_in`  in  DATA_W  carrier sample from `DDS_selector.sig_out`
- `mod_in`  in  DATA_W  modulated sample from `DDS_selector.mod_out`
- `rd_ready`  in  1  downstream accepts the current read word
- `rd_valid`  out  1  read word valid
- `rd_sig`  out  DATA_W  carrier sample being read
- `rd_mod`  out  DATA_W  modulated sample being read
- `rd_last`  out  1  marks the final word of the window
- `busy`  out  1  high in every state except IDLE

## Operation
- **States:** IDLE, PREFILL, ARMED, CAPTURE, READOUT.
- **IDLE**
  - No writes.
  - `arm`=1 → PREFILL; write pointer and fill counter clear to 0.
- **PREFILL**
  - Every `en` writes {sig_in, mod_in} at `wptr`; `wptr` increments modulo DEPTH.
  - After the PRE_TRIG-th write → ARMED.
  - Triggers are ignored in this state.
- **ARMED**
  - Every `en` keeps writing; the ring overwrites the oldest data.
  - Trigger = an `en` cycle with `trig_in`=1 while the value of `trig_in` sampled on the previous `en` cycle was 0.
  - The previous-sample register updates only on `en` cycles and resets to 1 on entry to PREFILL, so a level already high at arm time is not a trigger.
  - On trigger: that same sample is written at `wptr`, `trig_addr` ← `wptr`, state → CAPTURE.
- **CAPTURE**
  - Writes continue until DEPTH−PRE_TRIG samples, including the trigger sample, have been written since the trigger.
  - Then → READOUT, with `rptr` = (`trig_addr` − PRE_TRIG) mod DEPTH.
- **READOUT**
  - No writes; `en`, `trig_in` and `arm` are ignored.
  - Emits DEPTH words in chronological order starting at `rptr`.
  - `rd_last`=1 on word DEPTH−1.
  - The handshake on the last word → IDLE.
- **Handshake**
  - A transfer occurs when `rd_valid` & `rd_ready`.
  - While `rd_valid`=1 and `rd_ready`=0, `rd_sig`, `rd_mod` and `rd_last` hold stable.
- `arm` outside IDLE is ignored (no restart).
- **Pointer arithmetic:** all pointers are log2(DEPTH) bits with natural wrap; the counters never saturate.
- **Reset (async, any state):** → IDLE; `rd_valid`, `rd_last`, `busy` = 0; `rd_sig`, `rd_mod` = 0; pointers and counters = 0. RAM contents are undefined and never read before being written.

## Timing
- A write takes effect at the rising edge where `en`=1; the trigger decision is made in that same cycle.
- Storage is synchronous RAM with one-cycle read latency.
  - First `rd_valid` rises 2 cycles after the final CAPTURE write edge.
  - With `rd_ready` held at 1, one word transfers per cycle with no bubbles. The implementation prefetches the next word or uses an output skid register.
- READOUT → IDLE: `busy` falls on the clock edge following the last handshake.
- Full window (arm to IDLE) with `en` every cycle and `rd_ready`=1 = PRE_TRIG + (cycles spent waiting in ARMED) + (DEPTH−PRE_TRIG) + 2 + DEPTH cycles.

## Structure
- Shared package `dds_pkg`:
  - `capture_state_t` enum.
  - `DDS_W` = 12, reused by `DDS_selector`.
  - The packed sample struct {sig, mod}.
- Sub-module `capture_ram`: simple dual-port, one write port and one registered read port, width 2·DATA_W, depth DEPTH. Infers M10K on DE1-SoC.
- The FSM, pointers, edge detector and read skid register live in the top module.

## Test plan
Bench uses DEPTH=16, PRE_TRIG=4, `en` every cycle, `sig_in` = incrementing counter from 0, `mod_in` = ~`sig_in`.
- **Basic capture:** arm at sample 0, `trig_in` rises at sample 10, `rd_ready`=1 → 16 words with `rd_sig` = 6..21; `rd_last` only on 21; `busy` low after the last word.
- **Backpressure:** same stimulus, `rd_ready` toggling 1/0 each cycle → identical sequence with no duplicated or dropped words; outputs stable while stalled.
- **Trigger during prefill:** `trig_in` rises at sample 2, falls at 3, rises again at 12 → first captured word is 8 (only the edge at 12 counts).
- **Level high at arm:** `trig_in`=1 from before arm and held high → no trigger; `busy` stays 1 in ARMED; falling then rising `trig_in` triggers.
- **Sparse `en`:** `en` every 3rd cycle → captured words are consecutive counter values taken on `en` cycles only.
- **Reset mid-CAPTURE:** `reset` low for 1 cycle → outputs 0 and IDLE immediately; a new arm completes a correct capture.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS definitions: sample width, capture FSM states and the packed
// {sig, mod} sample word used by the DDS selector and the capture buffer.
package dds_pkg;

  localparam int DDS_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_ARMED,
    ST_CAPTURE,
    ST_READOUT
  } capture_state_t;

  typedef struct packed {
    logic signed [DDS_W-1:0] sig;
    logic signed [DDS_W-1:0] mod;
  } sample_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port with
// read enable so the read word holds while the readout pipeline is stalled.
module capture_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dds_capture_buffer.sv
// Trigger-aligned capture of the DDS carrier and modulated output into a ring
// buffer, with the captured window played back over a valid/ready stream.
module dds_capture_buffer
  import dds_pkg::*;
#(
  parameter int DATA_W   = DDS_W,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     arm,
  input  logic                     trig_in,
  input  logic signed [DATA_W-1:0] sig_in,
  input  logic signed [DATA_W-1:0] mod_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic signed [DATA_W-1:0] rd_sig,
  output logic signed [DATA_W-1:0] rd_mod,
  output logic                     rd_last,
  output logic                     busy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE_A    = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_LAST = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] CAP_LAST = AW'(DEPTH - PRE_TRIG - 1);
  localparam logic [AW-1:0] WIN_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);
  localparam bit            CAP_ONE  = (DEPTH - PRE_TRIG == 1);

  capture_state_t state, state_nxt;

  logic [AW-1:0] wptr, rptr, trig_addr, cnt;
  logic          trig_prev;
  logic          issue_done;
  logic          wr_en, trig_hit, out_free, move_p1, issue, xfer_last;
  logic          vld_p1, last_p1;
  logic [2*DATA_W-1:0] word_p1;

  assign wr_en     = en && (state inside {ST_PREFILL, ST_ARMED, ST_CAPTURE});
  assign trig_hit  = (state == ST_ARMED) && en && trig_in && !trig_prev;
  assign out_free  = !rd_valid || rd_ready;
  assign move_p1   = vld_p1 && out_free;
  assign issue     = (state == ST_READOUT) && !issue_done && (!vld_p1 || move_p1);
  assign xfer_last = rd_valid && rd_ready && rd_last;
  assign busy      = (state != ST_IDLE);

  capture_ram #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr),
    .wdata ({sig_in, mod_in}),
    .re    (issue),
    .raddr (rptr),
    .rdata (word_p1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arm) state_nxt = ST_PREFILL;
      ST_PREFILL: if (en && cnt == PRE_LAST) state_nxt = ST_ARMED;
      ST_ARMED:   if (trig_hit) state_nxt = CAP_ONE ? ST_READOUT : ST_CAPTURE;
      ST_CAPTURE: if (en && cnt == CAP_LAST) state_nxt = ST_READOUT;
      ST_READOUT: if (xfer_last) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Write side pointers, edge detector and read-address issue (feeds stage p1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      trig_addr  <= '0;
      cnt        <= '0;
      trig_prev  <= 1'b0;
      issue_done <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr      <= wptr + ONE_A;
        trig_prev <= trig_in;
      end
      case (state)
        ST_IDLE: if (arm) begin
          wptr      <= '0;
          cnt       <= '0;
          trig_prev <= 1'b1;
        end
        ST_PREFILL: if (en) cnt <= cnt + ONE_A;
        ST_ARMED: if (trig_hit) begin
          trig_addr <= wptr;
          cnt       <= ONE_A;
          if (CAP_ONE) begin
            rptr       <= wptr - PRE_A;
            cnt        <= '0;
            issue_done <= 1'b0;
          end
        end
        ST_CAPTURE: if (en) begin
          cnt <= cnt + ONE_A;
          if (cnt == CAP_LAST) begin
            rptr       <= trig_addr - PRE_A;
            cnt        <= '0;
            issue_done <= 1'b0;
          end
        end
        ST_READOUT: if (issue) begin
          rptr <= rptr + ONE_A;
          cnt  <= cnt + ONE_A;
          if (cnt == WIN_LAST) issue_done <= 1'b1;
        end
        default: ;
      endcase
      if (issue)        vld_p1 <= 1'b1;
      else if (move_p1) vld_p1 <= 1'b0;
      if (issue) last_p1 <= (cnt == WIN_LAST);
    end
  end

  // Output skid register (stage p2): holds the word while the sink stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_sig   <= '0;
      rd_mod   <= '0;
    end else if (move_p1) begin
      rd_valid         <= 1'b1;
      rd_last          <= last_p1;
      {rd_sig, rd_mod} <= word_p1;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

endmodule
